// File: rtl/pkt_out_stage_if.sv
// rtl/pkt_out_stage_if.sv - fifo_sram read port and egress pipeline signals of pkt_out_stage
interface pkt_out_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_output;
  logic                             fifo_empty;
  logic                             reb;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;

  // egress stage side
  modport master (
    input  fifo_output, fifo_empty, out_rdy,
    output reb, out_data, out_ctrl, out_wr
  );

  // fifo_sram and downstream side
  modport slave (
    output fifo_output, fifo_empty, out_rdy,
    input  reb, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/pkt_out_stage.sv
// rtl/pkt_out_stage.sv - fifo_sram egress stage with 2-entry skid buffer, packet framing and statistics (optional PKT_DROP_EN)
module pkt_out_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pkt_out_stage_if.master      bus,
  input  logic                 drop_req,
  output logic                 in_pkt,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int W = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_HDR, S_BODY, S_DROP_HDR, S_DROP_BODY} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   skid0, skid1;
  logic [1:0]     occ;
  logic           inflight;
  logic           avail;
  logic [W-1:0]   head;
  logic           head_nz;
  logic           drop_act;
  logic           pop;
  logic           in_pkt_nxt;
  logic           pkt_inc;
  logic           drop_inc;

  // A read is only issued when the returning word is guaranteed a skid slot
  assign bus.reb = !reset && !bus.fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);

  // With an empty buffer the word returning from the SRAM is presented directly,
  // which gives reb-to-out_wr latency of one cycle and 1 word/cycle streaming.
  assign avail   = (occ != 2'd0) || inflight;
  assign head    = (occ != 2'd0) ? skid0 : bus.fifo_output;
  assign head_nz = |head[W-1:DATA_WIDTH];

`ifdef PKT_DROP_EN
  assign drop_act = avail && ((state == S_DROP_HDR) || (state == S_DROP_BODY) ||
                              ((state == S_HDR) && !in_pkt && drop_req));
`else
  assign drop_act = 1'b0;
`endif

  assign bus.out_wr   = avail && bus.out_rdy && !drop_act;
  assign bus.out_data = avail ? head[DATA_WIDTH-1:0] : '0;
  assign bus.out_ctrl = avail ? head[W-1:DATA_WIDTH] : '0;
  assign pop          = bus.out_wr || (avail && drop_act);

  // Skid buffer: pop from the head, write returning words behind what remains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      inflight <= bus.reb;
      case (occ)
        2'd0: begin
          if (inflight && !pop) begin
            skid0 <= bus.fifo_output;
            occ   <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && inflight) begin
            skid0 <= bus.fifo_output;
          end else if (pop) begin
            occ <= 2'd0;
          end else if (inflight) begin
            skid1 <= bus.fifo_output;
            occ   <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            skid0 <= skid1;
            occ   <= 2'd1;
          end
        end
      endcase
    end
  end

  // Framing state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_HDR;
      in_pkt <= 1'b0;
    end else begin
      state  <= state_nxt;
      in_pkt <= in_pkt_nxt;
    end
  end

  // Framing next state: advances on every word leaving the head, forwarded or dropped
  always_comb begin
    state_nxt  = state;
    in_pkt_nxt = in_pkt;
    pkt_inc    = 1'b0;
    drop_inc   = 1'b0;
    if (pop) begin
      case (state)
        S_HDR: begin
          if (drop_act) begin
            state_nxt = head_nz ? S_DROP_HDR : S_DROP_BODY;
          end else begin
            in_pkt_nxt = 1'b1;
            if (!head_nz) state_nxt = S_BODY;
          end
        end
        S_BODY: begin
          if (head_nz) begin
            state_nxt  = S_HDR;
            in_pkt_nxt = 1'b0;
            pkt_inc    = 1'b1;
          end
        end
        S_DROP_HDR: begin
          if (!head_nz) state_nxt = S_DROP_BODY;
        end
        default: begin
          if (head_nz) begin
            state_nxt = S_HDR;
            drop_inc  = 1'b1;
          end
        end
      endcase
    end
  end

  // Forwarded packet and word statistics, wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      word_count <= '0;
    end else begin
      if (pkt_inc)    pkt_count  <= pkt_count + CNT_WIDTH'(1);
      if (bus.out_wr) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

`ifdef PKT_DROP_EN
  // Dropped packet statistic, counted on the dropped EOP word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_inc) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_req ^ drop_inc;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_pkt_out_stage.sv
// tb/tb_pkt_out_stage.sv - self-checking bench for pkt_out_stage with a queue-based fifo and stream model
module tb_pkt_out_stage;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = CW + DW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drop_req = 1'b0;
  logic        in_pkt;
  logic [31:0] pkt_count, word_count, drop_count;

  pkt_out_stage_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  pkt_out_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .drop_req(drop_req), .in_pkt(in_pkt),
    .pkt_count(pkt_count), .word_count(word_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  logic [NW-1:0] src_q[$];
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] got_q[$];
  int            got_cyc[$];
  int errors = 0, checks = 0, cyc = 0;
  int issued = 0, transferred = 0, max_out = 0, reb_empty_viol = 0, exp_pkts = 0;
  bit hold_empty = 1'b0;
  logic          s_reb, s_wr, s_in_pkt;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ctrl;
  logic [31:0]   s_pkt;

  // one clock: sample outputs at negedge, then play the SRAM (data the cycle after reb)
  task automatic tick();
    logic r;
    bus.fifo_empty = hold_empty || (src_q.size() == 0);
    @(negedge clk);
    s_reb = bus.reb; s_wr = bus.out_wr; s_data = bus.out_data; s_ctrl = bus.out_ctrl;
    s_in_pkt = in_pkt; s_pkt = pkt_count;
    if (bus.reb && bus.fifo_empty) reb_empty_viol++;
    if (issued + int'(bus.reb) - transferred > max_out) max_out = issued + int'(bus.reb) - transferred;
    if (bus.reb) issued++;
    if (bus.out_wr) begin
      got_q.push_back({bus.out_ctrl, bus.out_data});
      got_cyc.push_back(cyc);
      transferred++;
    end
    r = bus.reb;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      if (src_q.size() != 0) bus.fifo_output = src_q.pop_front();
      else bus.fifo_output = '0;
    end
    bus.fifo_empty = hold_empty || (src_q.size() == 0);
  endtask

  // packet = nhdr module headers (ctrl!=0), nbody words (ctrl==0), EOP (ctrl!=0)
  task automatic push_pkt(int nhdr, int nbody, bit dropped);
    logic [CW-1:0] c;
    logic [NW-1:0] w;
    for (int i = 0; i < nhdr + nbody + 1; i++) begin
      if (i < nhdr) c = CW'($urandom_range(1, 255));
      else if (i < nhdr + nbody) c = '0;
      else c = CW'($urandom_range(1, 255));
      w = {c, $urandom(), $urandom()};
      src_q.push_back(w);
      if (!dropped) exp_q.push_back(w);
    end
    if (!dropped) exp_pkts++;
  endtask

  task automatic run_until(int n, int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_q.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
    issued = 0; transferred = 0; max_out = 0; reb_empty_viol = 0; exp_pkts = 0;
    hold_empty = 1'b0; drop_req = 1'b0;
    bus.fifo_output = '0; bus.fifo_empty = 1'b1; bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_rdy = 1'b1;
    reset = 1'b1;
    src_q.push_back({8'hff, 64'h1});
    bus.fifo_empty = 1'b0;
    #1;
    checks++; if (bus.reb !== 1'b0) begin errors++; $display("FAIL rst_reb_held got=%b exp=0", bus.reb); end
    do_reset();
    #1;
    checks++; if (bus.reb !== 1'b0) begin errors++; $display("FAIL rst_reb got=%b exp=0", bus.reb); end
    checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL rst_out_wr got=%b exp=0", bus.out_wr); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_ctrl !== '0) begin errors++; $display("FAIL rst_out_ctrl got=%h exp=0", bus.out_ctrl); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL rst_in_pkt got=%b exp=0", in_pkt); end
    checks++; if (pkt_count !== 0) begin errors++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (word_count !== 0) begin errors++; $display("FAIL rst_word_count got=%0d exp=0", word_count); end
    checks++; if (drop_count !== 0) begin errors++; $display("FAIL rst_drop_count got=%0d exp=0", drop_count); end
  endtask

  task automatic test_basic();
    logic ip[10];
    int c0;
    do_reset();
    src_q.push_back({8'hff, 64'h0123_4567_89ab_cdef}); exp_q.push_back({8'hff, 64'h0123_4567_89ab_cdef});
    src_q.push_back({8'h00, 64'hdead_beef_0000_0001}); exp_q.push_back({8'h00, 64'hdead_beef_0000_0001});
    src_q.push_back({8'h01, 64'hfeed_f00d_0000_0002}); exp_q.push_back({8'h01, 64'hfeed_f00d_0000_0002});
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin tick(); ip[i] = s_in_pkt; end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL basic_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 3) begin
      checks++; if (got_cyc[0] != c0 + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", got_cyc[0] - c0, 1); end
      checks++; if (got_cyc[2] != got_cyc[0] + 2 || got_cyc[1] != got_cyc[0] + 1) begin errors++; $display("FAIL basic_consecutive got=%0d,%0d,%0d", got_cyc[0], got_cyc[1], got_cyc[2]); end
      checks++; if (ip[got_cyc[0] - c0 + 1] !== 1'b1) begin errors++; $display("FAIL basic_in_pkt_set got=%b exp=1", ip[got_cyc[0] - c0 + 1]); end
      checks++; if (ip[got_cyc[2] - c0 + 1] !== 1'b0) begin errors++; $display("FAIL basic_in_pkt_clr got=%b exp=0", ip[got_cyc[2] - c0 + 1]); end
    end
    checks++; if (pkt_count !== 1) begin errors++; $display("FAIL basic_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (word_count !== 3) begin errors++; $display("FAIL basic_word_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int p = 0; p < 6; p++) push_pkt(1, 9, 1'b0);
    for (int i = 0; i < 600 && got_q.size() < 66; i++) begin
      bus.out_rdy = (i % 2 == 0);
      tick();
    end
    bus.out_rdy = 1'b1;
    checks++; if (got_q.size() != 66) begin errors++; $display("FAIL stream_count got=%0d exp=66", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL stream_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (max_out > 2) begin errors++; $display("FAIL stream_outstanding got=%0d exp<=2", max_out); end
    checks++; if (reb_empty_viol != 0) begin errors++; $display("FAIL stream_reb_empty got=%0d exp=0", reb_empty_viol); end
    checks++; if (word_count !== 66) begin errors++; $display("FAIL stream_word_count got=%0d exp=66", word_count); end
    checks++; if (pkt_count !== exp_pkts) begin errors++; $display("FAIL stream_pkt_count got=%0d exp=%0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_latency();
    do_reset();
    hold_empty = 1'b1;
    push_pkt(1, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (s_reb !== 1'b0) begin errors++; $display("FAIL lat_empty_reb[%0d] got=%b exp=0", i, s_reb); end
      checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL lat_empty_wr[%0d] got=%b exp=0", i, s_wr); end
    end
    hold_empty = 1'b0;
    tick();
    checks++; if (s_reb !== 1'b1) begin errors++; $display("FAIL lat_reb_T got=%b exp=1", s_reb); end
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL lat_wr_T got=%b exp=0", s_wr); end
    tick();
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL lat_wr_T1 got=%b exp=1", s_wr); end
    checks++; if ({s_ctrl, s_data} !== exp_q[0]) begin errors++; $display("FAIL lat_data_T1 got=%h exp=%h", {s_ctrl, s_data}, exp_q[0]); end
    run_until(3, 20);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL lat_count got=%0d exp=3", got_q.size()); end
    checks++; if (pkt_count !== 1) begin errors++; $display("FAIL lat_pkt_count got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_eop_hold();
    do_reset();
    push_pkt(1, 1, 1'b0);
    run_until(2, 20);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL hold_pre_count got=%0d exp=2", got_q.size()); end
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({s_ctrl, s_data} !== exp_q[2]) begin errors++; $display("FAIL hold_data[%0d] got=%h exp=%h", i, {s_ctrl, s_data}, exp_q[2]); end
      checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL hold_wr[%0d] got=%b exp=0", i, s_wr); end
      checks++; if (s_pkt !== 0) begin errors++; $display("FAIL hold_pkt[%0d] got=%0d exp=0", i, s_pkt); end
    end
    bus.out_rdy = 1'b1;
    tick();
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL hold_release_wr got=%b exp=1", s_wr); end
    checks++; if (s_pkt !== 0) begin errors++; $display("FAIL hold_release_pkt got=%0d exp=0", s_pkt); end
    tick();
    checks++; if (s_pkt !== 1) begin errors++; $display("FAIL hold_after_pkt got=%0d exp=1", s_pkt); end
    checks++; if (got_q.size() != 3 || got_q[got_q.size()-1] !== exp_q[2]) begin errors++; $display("FAIL hold_eop_word got_n=%0d exp_n=3", got_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_pkt(1, 3, 1'b0);
    run_until(1, 20);
    bus.out_rdy = 1'b0;
    repeat (4) tick();
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL areset_pre_wr got=%b exp=0", s_wr); end
    checks++; if (s_in_pkt !== 1'b1) begin errors++; $display("FAIL areset_pre_in_pkt got=%b exp=1", s_in_pkt); end
    checks++; if ({s_ctrl, s_data} !== exp_q[1]) begin errors++; $display("FAIL areset_pre_head got=%h exp=%h", {s_ctrl, s_data}, exp_q[1]); end
    checks++; if (word_count !== 1) begin errors++; $display("FAIL areset_pre_words got=%0d exp=1", word_count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.reb !== 1'b0) begin errors++; $display("FAIL areset_reb got=%b exp=0", bus.reb); end
    checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL areset_out_wr got=%b exp=0", bus.out_wr); end
    checks++; if ({bus.out_ctrl, bus.out_data} !== '0) begin errors++; $display("FAIL areset_out got=%h exp=0", {bus.out_ctrl, bus.out_data}); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL areset_in_pkt got=%b exp=0", in_pkt); end
    checks++; if (pkt_count !== 0 || word_count !== 0 || drop_count !== 0) begin errors++; $display("FAIL areset_counters got=%0d/%0d/%0d exp=0/0/0", pkt_count, word_count, drop_count); end
    do_reset();
    push_pkt(1, 1, 1'b0);
    run_until(3, 30);
    tick();
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL areset_post_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL areset_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL areset_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== 1) begin errors++; $display("FAIL areset_post_pkt got=%0d exp=1", pkt_count); end
    checks++; if (word_count !== 3) begin errors++; $display("FAIL areset_post_words got=%0d exp=3", word_count); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL areset_post_in_pkt got=%b exp=0", in_pkt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < 10; p++) push_pkt($urandom_range(0, 2), $urandom_range(1, 6), 1'b0);
    for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) begin
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 7) == 0);
      tick();
    end
    hold_empty = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL rand_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (pkt_count !== exp_pkts) begin errors++; $display("FAIL rand_pkt_count got=%0d exp=%0d", pkt_count, exp_pkts); end
    checks++; if (word_count !== exp_q.size()) begin errors++; $display("FAIL rand_word_count got=%0d exp=%0d", word_count, exp_q.size()); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL rand_outstanding got=%0d exp<=2", max_out); end
    checks++; if (reb_empty_viol != 0) begin errors++; $display("FAIL rand_reb_empty got=%0d exp=0", reb_empty_viol); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL rand_in_pkt got=%b exp=0", in_pkt); end
  endtask

`ifdef PKT_DROP_EN
  task automatic test_drop();
    int wr_seen;
    do_reset();
    wr_seen = 0;
    drop_req = 1'b1;
    push_pkt(1, 2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      bus.out_rdy = $urandom_range(0, 1);
      tick();
      if (s_wr) wr_seen++;
    end
    checks++; if (wr_seen != 0) begin errors++; $display("FAIL drop_wr got=%0d exp=0", wr_seen); end
    checks++; if (src_q.size() != 0) begin errors++; $display("FAIL drop_consumed got=%0d exp=0", src_q.size()); end
    checks++; if (drop_count !== 1) begin errors++; $display("FAIL drop_count_mid got=%0d exp=1", drop_count); end
    checks++; if (in_pkt !== 1'b0) begin errors++; $display("FAIL drop_in_pkt got=%b exp=0", in_pkt); end
    drop_req = 1'b0;
    bus.out_rdy = 1'b1;
    push_pkt(1, 1, 1'b0);
    run_until(3, 30);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL drop_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drop_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_count !== 1) begin errors++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
    checks++; if (pkt_count !== 1) begin errors++; $display("FAIL drop_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (word_count !== 3) begin errors++; $display("FAIL drop_word_count got=%0d exp=3", word_count); end
  endtask
`else
  task automatic test_drop();
    do_reset();
    drop_req = 1'b1;
    push_pkt(1, 2, 1'b0);
    push_pkt(0, 1, 1'b0);
    run_until(6, 40);
    tick();
    drop_req = 1'b0;
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL nodrop_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin errors++; $display("FAIL nodrop_word[%0d] got=none exp=%h", i, exp_q[i]); end
      else if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL nodrop_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (drop_count !== 0) begin errors++; $display("FAIL nodrop_drop_count got=%0d exp=0", drop_count); end
    checks++; if (pkt_count !== 2) begin errors++; $display("FAIL nodrop_pkt_count got=%0d exp=2", pkt_count); end
  endtask
`endif

  initial begin
    bus.fifo_output = '0;
    bus.fifo_empty  = 1'b1;
    bus.out_rdy     = 1'b1;
    test_reset();
    test_basic();
    test_stream();
    test_latency();
    test_eop_hold();
    test_async_reset();
    test_random();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
